// File: rtl/trb_mem_ctrl.sv
// Trace buffer memory controller: a trigger-frozen ring buffer in trace mode and a plain FIFO
// in stream mode, both read out through a one-cycle grant handshake.
module trb_mem_ctrl #(
  parameter int unsigned TRB_WIDTH      = 32,
  parameter int unsigned TRB_DEPTH      = 16,
  parameter int unsigned TRB_DELAY_BITS = 8
) (
  input  logic                        FPGA_CLK_I,
  input  logic                        RST_I,
  input  logic                        MODE_I,
  input  logic                        TRG_EVENT_I,
  input  logic [TRB_DELAY_BITS-1:0]   TRG_DELAY_I,
  output logic                        TRG_DELAYED_O,
  input  logic                        STORE_I,
  input  logic [TRB_WIDTH-1:0]        DATA_I,
  output logic                        STORE_PERM_O,
  input  logic                        LOAD_REQUEST_I,
  output logic                        LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0]        DATA_O,
  output logic [$clog2(TRB_DEPTH):0]  FILL_O,
  output logic                        OVERFLOW_O
);

  localparam int unsigned PtrW = $clog2(TRB_DEPTH);
  localparam logic [PtrW:0] FillMax = (PtrW + 1)'(TRB_DEPTH);
  localparam logic [PtrW:0] FillOne = (PtrW + 1)'(1);

  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

  logic                      mode_q;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]             fill_q, fill_d;
  logic [TRB_DELAY_BITS-1:0] dly_cnt_q, dly_cnt_d, cnt_next;
  logic                      armed_q, armed_d;
  logic                      frozen_q, frozen_d;
  logic                      done_q, done_d;
  logic                      delayed_q, delayed_d;
  logic                      grant_q;
  logic [TRB_WIDTH-1:0]      data_q, data_d;
  logic                      overflow_q, overflow_d;

  logic mode_chg, store_perm, store_acc, avail, grant;

  always_comb begin
    mode_chg   = MODE_I != mode_q;
    store_perm = MODE_I ? (fill_q != FillMax) : !frozen_q;
    store_acc  = STORE_I && store_perm && !mode_chg;
    avail      = MODE_I ? (fill_q != '0) : (frozen_q && !done_q && fill_q != '0);
    // Requester drops its request one cycle after a grant, so never grant back to back.
    grant      = LOAD_REQUEST_I && avail && !grant_q && !mode_chg;

    wr_ptr_d   = wr_ptr_q + PtrW'(store_acc);
    rd_ptr_d   = rd_ptr_q + PtrW'(grant);
    dly_cnt_d  = dly_cnt_q;
    cnt_next   = dly_cnt_q;
    armed_d    = armed_q;
    frozen_d   = frozen_q;
    done_d     = done_q;
    delayed_d  = delayed_q;
    overflow_d = overflow_q || (STORE_I && !store_perm);
    data_d     = grant ? mem[rd_ptr_q] : data_q;

    // Trace mode saturates fill so the ring keeps only the newest TRB_DEPTH words.
    fill_d = fill_q;
    if (store_acc && !grant && fill_q != FillMax) begin
      fill_d = fill_q + FillOne;
    end else if (grant && !store_acc) begin
      fill_d = fill_q - FillOne;
    end

    if (!MODE_I) begin
      if (TRG_EVENT_I && !armed_q) begin
        armed_d = 1'b1;
      end
      if ((armed_q || TRG_EVENT_I) && !frozen_q) begin
        cnt_next  = (armed_q ? dly_cnt_q : '0) + TRB_DELAY_BITS'(store_acc);
        dly_cnt_d = cnt_next;
        if (cnt_next == TRG_DELAY_I || TRG_DELAY_I == '0) begin
          frozen_d  = 1'b1;
          delayed_d = 1'b1;
          rd_ptr_d  = wr_ptr_d - fill_d[PtrW-1:0];
        end
      end
      if (grant && fill_d == '0) begin
        done_d = 1'b1;
      end
    end

    if (mode_chg) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      dly_cnt_d  = '0;
      armed_d    = 1'b0;
      frozen_d   = 1'b0;
      done_d     = 1'b0;
      delayed_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      dly_cnt_q  <= '0;
      armed_q    <= 1'b0;
      frozen_q   <= 1'b0;
      done_q     <= 1'b0;
      delayed_q  <= 1'b0;
      grant_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      mode_q     <= MODE_I;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      dly_cnt_q  <= dly_cnt_d;
      armed_q    <= armed_d;
      frozen_q   <= frozen_d;
      done_q     <= done_d;
      delayed_q  <= delayed_d;
      grant_q    <= grant;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge FPGA_CLK_I) begin
    if (store_acc) begin
      mem[wr_ptr_q] <= DATA_I;
    end
  end

  assign TRG_DELAYED_O = delayed_q;
  assign STORE_PERM_O  = store_perm;
  assign LOAD_GRANT_O  = grant_q;
  assign DATA_O        = data_q;
  assign FILL_O        = fill_q;
  assign OVERFLOW_O    = overflow_q;

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// Scoreboard bench for trb_mem_ctrl: expected words are queued as stores are accepted and
// compared against the logged grant stream.
module tb_trb_mem_ctrl;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int DB = 8;
  localparam int FW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode, trg_event, store, req;
  logic [DB-1:0] trg_delay;
  logic [W-1:0]  data_i;
  logic          trg_delayed, store_perm, grant, overflow;
  logic [W-1:0]  data_o;
  logic [FW-1:0] fill;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int log_rd = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] grant_log[$];
  int           grant_cyc[$];
  bit m_frozen, m_armed;
  int m_cnt;

  trb_mem_ctrl #(
    .TRB_WIDTH(W),
    .TRB_DEPTH(D),
    .TRB_DELAY_BITS(DB)
  ) dut (
    .FPGA_CLK_I    (clk),
    .RST_I         (rst),
    .MODE_I        (mode),
    .TRG_EVENT_I   (trg_event),
    .TRG_DELAY_I   (trg_delay),
    .TRG_DELAYED_O (trg_delayed),
    .STORE_I       (store),
    .DATA_I        (data_i),
    .STORE_PERM_O  (store_perm),
    .LOAD_REQUEST_I(req),
    .LOAD_GRANT_O  (grant),
    .DATA_O        (data_o),
    .FILL_O        (fill),
    .OVERFLOW_O    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (grant === 1'b1) begin
      grant_log.push_back(data_o);
      grant_cyc.push_back(cyc);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1;
    mode = m;
    trg_event = 1'b0;
    trg_delay = '0;
    store = 1'b0;
    data_i = '0;
    req = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b0;
    step;
    step;
    exp_q.delete();
    log_rd = grant_log.size();
    m_frozen = 1'b0;
    m_armed = 1'b0;
    m_cnt = 0;
  endtask

  // One trace-mode cycle; the model tracks which stores the ring should keep.
  task automatic trace_cycle(input logic st, input logic [W-1:0] d, input logic ev);
    logic acc;
    store = st;
    data_i = d;
    trg_event = ev;
    acc = st && !m_frozen;
    if (acc) begin
      exp_q.push_back(d);
      if (exp_q.size() > D) exp_q.delete(0);
    end
    if (ev && !m_frozen) begin
      if (!m_armed) begin
        m_armed = 1'b1;
        m_cnt = 0;
      end
      if (acc) m_cnt++;
      if (m_cnt == int'(trg_delay) || trg_delay == '0) m_frozen = 1'b1;
    end
    step;
  endtask

  task automatic hold_request(input int n);
    store = 1'b0;
    req = 1'b1;
    repeat (n) step;
    req = 1'b0;
    step;
    step;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++; if (trg_delayed !== 1'b0) begin errors++; $display("FAIL reset delayed: got %b want 0", trg_delayed); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset grant: got %b want 0", grant); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset data: got %h want 0", data_o); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL reset fill: got %0d want 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
    checks++; if (store_perm !== 1'b1) begin errors++; $display("FAIL reset perm trace: got %b want 1", store_perm); end
    mode = 1'b1;
    step;
    step;
    checks++; if (store_perm !== 1'b1) begin errors++; $display("FAIL reset perm stream: got %b want 1", store_perm); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL reset fill stream: got %0d want 0", fill); end
  endtask

  task automatic test_stream_fifo;
    logic [W-1:0] w;
    int first;
    do_reset(1'b1);
    for (int i = 1; i <= D; i++) begin
      store = 1'b1;
      data_i = W'(i);
      exp_q.push_back(W'(i));
      step;
      checks++; if (fill !== FW'(i)) begin errors++; $display("FAIL fifo fill: got %0d want %0d", fill, i); end
    end
    checks++; if (store_perm !== 1'b0) begin errors++; $display("FAIL fifo perm full: got %b want 0", store_perm); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fifo early overflow: got %b want 0", overflow); end
    data_i = 32'h11;
    step;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fifo overflow: got %b want 1", overflow); end
    checks++; if (fill !== FW'(D)) begin errors++; $display("FAIL fifo fill after drop: got %0d want %0d", fill, D); end
    first = log_rd;
    hold_request(40);
    checks++;
    if (grant_log.size() - log_rd != D) begin
      errors++; $display("FAIL fifo grant count: got %0d want %0d", grant_log.size() - log_rd, D);
    end else begin
      checks++;
      if (grant_cyc[first + D - 1] - grant_cyc[first] != 2 * (D - 1)) begin
        errors++;
        $display("FAIL fifo grant spacing: got %0d cycles want %0d",
                 grant_cyc[first + D - 1] - grant_cyc[first], 2 * (D - 1));
      end
    end
    while (log_rd < grant_log.size()) begin
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      checks++; if (grant_log[log_rd] !== w) begin errors++; $display("FAIL fifo data: got %h want %h", grant_log[log_rd], w); end
      log_rd++;
    end
    checks++; if (fill !== '0) begin errors++; $display("FAIL fifo final fill: got %0d want 0", fill); end
  endtask

  task automatic test_stream_simultaneous;
    logic [W-1:0] w;
    do_reset(1'b1);
    for (int i = 1; i <= 3; i++) begin
      store = 1'b1;
      data_i = 32'hA0 + W'(i);
      exp_q.push_back(data_i);
      step;
    end
    data_i = 32'hA4;
    exp_q.push_back(data_i);
    req = 1'b1;
    step;
    store = 1'b0;
    req = 1'b0;
    w = exp_q.pop_front();
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL simul grant: got %b want 1", grant); end
    checks++; if (data_o !== w) begin errors++; $display("FAIL simul data: got %h want %h", data_o, w); end
    checks++; if (fill !== FW'(3)) begin errors++; $display("FAIL simul fill: got %0d want 3", fill); end
    step;
    log_rd = grant_log.size();
    hold_request(10);
    checks++; if (grant_log.size() - log_rd != 3) begin errors++; $display("FAIL simul rest count: got %0d want 3", grant_log.size() - log_rd); end
    while (log_rd < grant_log.size()) begin
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      checks++; if (grant_log[log_rd] !== w) begin errors++; $display("FAIL simul rest data: got %h want %h", grant_log[log_rd], w); end
      log_rd++;
    end
  endtask

  task automatic test_trace_delay;
    logic [W-1:0] w;
    do_reset(1'b0);
    trg_delay = 8'd4;
    for (int i = 0; i < 20; i++) begin
      trace_cycle(1'b1, W'(i), i >= 9);
      checks++; if (trg_delayed !== m_frozen) begin errors++; $display("FAIL delay flag at %0d: got %b want %b", i, trg_delayed, m_frozen); end
      checks++; if (fill !== FW'(exp_q.size())) begin errors++; $display("FAIL delay fill at %0d: got %0d want %0d", i, fill, exp_q.size()); end
    end
    checks++; if (store_perm !== 1'b0) begin errors++; $display("FAIL delay perm: got %b want 0", store_perm); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL delay overflow: got %b want 1", overflow); end
    hold_request(40);
    hold_request(6);
    checks++; if (grant_log.size() - log_rd != 13) begin errors++; $display("FAIL delay grant count: got %0d want 13", grant_log.size() - log_rd); end
    while (log_rd < grant_log.size()) begin
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      checks++; if (grant_log[log_rd] !== w) begin errors++; $display("FAIL delay data: got %h want %h", grant_log[log_rd], w); end
      log_rd++;
    end
    checks++; if (fill !== '0) begin errors++; $display("FAIL delay final fill: got %0d want 0", fill); end
  endtask

  task automatic test_trace_wrap;
    logic [W-1:0] w;
    do_reset(1'b0);
    trg_delay = 8'd25;
    for (int i = 0; i < 32; i++) trace_cycle(1'b1, 32'h100 + W'(i), 1'b1);
    checks++; if (trg_delayed !== 1'b1) begin errors++; $display("FAIL wrap delayed: got %b want 1", trg_delayed); end
    checks++; if (fill !== FW'(D)) begin errors++; $display("FAIL wrap fill: got %0d want %0d", fill, D); end
    hold_request(40);
    checks++; if (grant_log.size() - log_rd != D) begin errors++; $display("FAIL wrap grant count: got %0d want %0d", grant_log.size() - log_rd, D); end
    while (log_rd < grant_log.size()) begin
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      checks++; if (grant_log[log_rd] !== w) begin errors++; $display("FAIL wrap data: got %h want %h", grant_log[log_rd], w); end
      log_rd++;
    end
  endtask

  task automatic test_trace_delay0;
    logic [W-1:0] w;
    do_reset(1'b0);
    trg_delay = 8'd0;
    for (int i = 0; i < 5; i++) trace_cycle(1'b1, 32'h200 + W'(i), 1'b0);
    trace_cycle(1'b1, 32'h205, 1'b1);
    checks++; if (trg_delayed !== 1'b1) begin errors++; $display("FAIL d0 delayed: got %b want 1", trg_delayed); end
    checks++; if (fill !== FW'(6)) begin errors++; $display("FAIL d0 fill: got %0d want 6", fill); end
    trace_cycle(1'b1, 32'h206, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL d0 overflow: got %b want 1", overflow); end
    hold_request(20);
    checks++; if (grant_log.size() - log_rd != 6) begin errors++; $display("FAIL d0 grant count: got %0d want 6", grant_log.size() - log_rd); end
    while (log_rd < grant_log.size()) begin
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      checks++; if (grant_log[log_rd] !== w) begin errors++; $display("FAIL d0 data: got %h want %h", grant_log[log_rd], w); end
      log_rd++;
    end
  endtask

  task automatic test_mode_toggle;
    do_reset(1'b0);
    trg_delay = 8'd0;
    trace_cycle(1'b1, 32'h300, 1'b0);
    trace_cycle(1'b1, 32'h301, 1'b0);
    trace_cycle(1'b1, 32'h302, 1'b1);
    trace_cycle(1'b1, 32'h303, 1'b1);
    checks++; if (trg_delayed !== 1'b1 || fill !== FW'(3) || overflow !== 1'b1) begin
      errors++; $display("FAIL toggle setup: got delayed %b fill %0d ovf %b want 1 3 1", trg_delayed, fill, overflow);
    end
    store = 1'b0;
    trg_event = 1'b0;
    mode = 1'b1;
    req = 1'b1;
    step;
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL toggle grant: got %b want 0", grant); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL toggle fill: got %0d want 0", fill); end
    checks++; if (trg_delayed !== 1'b0) begin errors++; $display("FAIL toggle delayed: got %b want 0", trg_delayed); end
    checks++; if (store_perm !== 1'b1) begin errors++; $display("FAIL toggle perm: got %b want 1", store_perm); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL toggle overflow: got %b want 0", overflow); end
    req = 1'b0;
    step;
    checks++; if (grant_log.size() != log_rd) begin errors++; $display("FAIL toggle stray grants: got %0d want 0", grant_log.size() - log_rd); end
    exp_q.delete();
  endtask

  task automatic test_async_reset;
    do_reset(1'b1);
    store = 1'b1;
    data_i = 32'h400;
    step;
    data_i = 32'h401;
    step;
    store = 1'b0;
    req = 1'b1;
    for (int k = 0; k < 6 && grant !== 1'b1; k++) step;
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL areset grant: got %b want 1", grant); end
    checks++; if (data_o !== 32'h400) begin errors++; $display("FAIL areset data: got %h want 400", data_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL areset grant clr: got %b want 0", grant); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL areset data clr: got %h want 0", data_o); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL areset fill clr: got %0d want 0", fill); end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step;
    log_rd = grant_log.size();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_stream_fifo;
    test_stream_simultaneous;
    test_trace_delay;
    test_trace_wrap;
    test_trace_delay0;
    test_mode_toggle;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
